// File: rtl/camera_pkg.sv
// Shared camera types and Q16.16 vector helpers used by the ray direction generator.
package camera_pkg;

    localparam int FRAC_BITS = 16;
    localparam int ONE_Q16   = 65536;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_STEP,
        SETUP_BASE,
        RUN,
        DONE
    } ray_state_t;

    // All vector arithmetic wraps modulo 2^32 per component.
    function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
        vec3_t r;
        r.x = a.x + b.x;
        r.y = a.y + b.y;
        r.z = a.z + b.z;
        return r;
    endfunction

    function automatic vec3_t vec3_sub(input vec3_t a, input vec3_t b);
        vec3_t r;
        r.x = a.x - b.x;
        r.y = a.y - b.y;
        r.z = a.z - b.z;
        return r;
    endfunction

    function automatic vec3_t vec3_mul_int(input vec3_t a, input logic signed [31:0] k);
        vec3_t r;
        r.x = a.x * k;
        r.y = a.y * k;
        r.z = a.z * k;
        return r;
    endfunction

endpackage

// File: rtl/vec3_scale.sv
// Combinational vec3 x Q16.16 scalar; each lane keeps the low 32 bits of (product >>> FRAC_BITS).
module vec3_scale
    import camera_pkg::*;
(
    input  vec3_t              v_i,
    input  logic signed [31:0] s_i,
    output vec3_t              p_o
);

    logic [95:0] v_flat;
    logic [95:0] p_flat;

    assign v_flat = v_i;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic signed [63:0] prod;
        assign prod = 64'($signed(v_flat[gi*32 +: 32])) * 64'(s_i);
        assign p_flat[gi*32 +: 32] = 32'(prod >>> FRAC_BITS);
    end

    assign p_o = p_flat;

endmodule

// File: rtl/ray_direction_gen.sv
// Per-frame raster ray direction generator: multiplies only during setup, then walks the
// image plane with incremental adds over a valid/ready stream.
module ray_direction_gen
    import camera_pkg::*;
#(
    parameter int H_RES    = 320,
    parameter int V_RES    = 180,
    parameter int STEP_Q16 = 410
) (
    input  logic                       clk_100mhz,
    input  logic                       rst_in,
    input  logic                       frame_start_in,
    input  logic [31:0]                x_forward,
    input  logic [31:0]                y_forward,
    input  logic [31:0]                z_forward,
    input  logic [31:0]                x_up,
    input  logic [31:0]                y_up,
    input  logic [31:0]                z_up,
    input  logic [31:0]                x_right,
    input  logic [31:0]                y_right,
    input  logic [31:0]                z_right,
    output logic                       ray_valid_out,
    input  logic                       ray_ready_in,
    output logic [31:0]                ray_x_out,
    output logic [31:0]                ray_y_out,
    output logic [31:0]                ray_z_out,
    output logic [$clog2(H_RES)-1:0]   pixel_x_out,
    output logic [$clog2(V_RES)-1:0]   pixel_y_out,
    output logic                       busy_out,
    output logic                       frame_done_out
);

    localparam int PXW = $clog2(H_RES);
    localparam int PYW = $clog2(V_RES);
    localparam logic [PXW-1:0] PX_LAST = PXW'(H_RES - 1);
    localparam logic [PYW-1:0] PY_LAST = PYW'(V_RES - 1);
    localparam logic signed [31:0] STEP_S = 32'(STEP_Q16);
    localparam logic signed [31:0] HALF_H = 32'(H_RES / 2);
    localparam logic signed [31:0] HALF_V = 32'(V_RES / 2);

    ray_state_t     state_q, state_d;
    vec3_t          fwd_q, fwd_d;
    vec3_t          right_q, right_d;
    vec3_t          up_q, up_d;
    vec3_t          rstep_q, rstep_d;
    vec3_t          ustep_q, ustep_d;
    vec3_t          row_base_q, row_base_d;
    vec3_t          cur_q, cur_d;
    logic [PXW-1:0] px_q, px_d;
    logic [PYW-1:0] py_q, py_d;

    vec3_t right_scaled;
    vec3_t up_scaled;
    vec3_t next_row_base;

    vec3_scale u_right_scale (
        .v_i (right_q),
        .s_i (STEP_S),
        .p_o (right_scaled)
    );

    vec3_scale u_up_scale (
        .v_i (up_q),
        .s_i (STEP_S),
        .p_o (up_scaled)
    );

    // Moving down one row steps against the up vector.
    assign next_row_base = vec3_sub(row_base_q, ustep_q);

    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            fwd_q      <= '0;
            right_q    <= '0;
            up_q       <= '0;
            rstep_q    <= '0;
            ustep_q    <= '0;
            row_base_q <= '0;
            cur_q      <= '0;
            px_q       <= '0;
            py_q       <= '0;
        end else begin
            state_q    <= state_d;
            fwd_q      <= fwd_d;
            right_q    <= right_d;
            up_q       <= up_d;
            rstep_q    <= rstep_d;
            ustep_q    <= ustep_d;
            row_base_q <= row_base_d;
            cur_q      <= cur_d;
            px_q       <= px_d;
            py_q       <= py_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fwd_d      = fwd_q;
        right_d    = right_q;
        up_d       = up_q;
        rstep_d    = rstep_q;
        ustep_d    = ustep_q;
        row_base_d = row_base_q;
        cur_d      = cur_q;
        px_d       = px_q;
        py_d       = py_q;

        case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    fwd_d   = '{x: x_forward, y: y_forward, z: z_forward};
                    right_d = '{x: x_right,   y: y_right,   z: z_right};
                    up_d    = '{x: x_up,      y: y_up,      z: z_up};
                    state_d = SETUP_STEP;
                end
            end
            SETUP_STEP: begin
                rstep_d = right_scaled;
                ustep_d = up_scaled;
                state_d = SETUP_BASE;
            end
            SETUP_BASE: begin
                // Top-left pixel: half a row to the left, half a frame upward.
                row_base_d = vec3_add(vec3_sub(fwd_q, vec3_mul_int(rstep_q, HALF_H)),
                                      vec3_mul_int(ustep_q, HALF_V));
                cur_d      = row_base_d;
                px_d       = '0;
                py_d       = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (ray_ready_in) begin
                    if (px_q == PX_LAST) begin
                        if (py_q == PY_LAST) begin
                            state_d = DONE;
                        end else begin
                            px_d       = '0;
                            py_d       = py_q + 1'b1;
                            row_base_d = next_row_base;
                            cur_d      = next_row_base;
                        end
                    end else begin
                        px_d  = px_q + 1'b1;
                        cur_d = vec3_add(cur_q, rstep_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ray_valid_out  = (state_q == RUN);
    assign busy_out       = (state_q == SETUP_STEP) || (state_q == SETUP_BASE) || (state_q == RUN);
    assign frame_done_out = (state_q == DONE);
    assign ray_x_out      = cur_q.x;
    assign ray_y_out      = cur_q.y;
    assign ray_z_out      = cur_q.z;
    assign pixel_x_out    = px_q;
    assign pixel_y_out    = py_q;

endmodule

// File: tb/tb_ray_direction_gen.sv
// Bench for ray_direction_gen: small 4x2 frames plus one full default-resolution frame,
// checked against a closed-form per-pixel ray model.
module tb_ray_direction_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] xf, yf, zf, xu, yu, zu, xr, yr, zr;

    logic        fs_s, rdy_s, v_s, busy_s, done_s;
    logic [31:0] rx_s, ry_s, rz_s;
    logic [1:0]  px_s;
    logic [0:0]  py_s;

    logic        fs_d, rdy_d, v_d, busy_d, done_d;
    logic [31:0] rx_d, ry_d, rz_d;
    logic [8:0]  px_d;
    logic [7:0]  py_d;

    int total = 0;
    int bad   = 0;

    int F[3] = '{0, 0, 65536};
    int R[3] = '{65536, 0, 0};
    int U[3] = '{0, 65536, 0};

    ray_direction_gen #(.H_RES(4), .V_RES(2), .STEP_Q16(16384)) dut_s (
        .clk_100mhz(clk), .rst_in(rst), .frame_start_in(fs_s),
        .x_forward(xf), .y_forward(yf), .z_forward(zf),
        .x_up(xu), .y_up(yu), .z_up(zu),
        .x_right(xr), .y_right(yr), .z_right(zr),
        .ray_valid_out(v_s), .ray_ready_in(rdy_s),
        .ray_x_out(rx_s), .ray_y_out(ry_s), .ray_z_out(rz_s),
        .pixel_x_out(px_s), .pixel_y_out(py_s),
        .busy_out(busy_s), .frame_done_out(done_s)
    );

    ray_direction_gen dut_d (
        .clk_100mhz(clk), .rst_in(rst), .frame_start_in(fs_d),
        .x_forward(xf), .y_forward(yf), .z_forward(zf),
        .x_up(xu), .y_up(yu), .z_up(zu),
        .x_right(xr), .y_right(yr), .z_right(zr),
        .ray_valid_out(v_d), .ray_ready_in(rdy_d),
        .ray_x_out(rx_d), .ray_y_out(ry_d), .ray_z_out(rz_d),
        .pixel_x_out(px_d), .pixel_y_out(py_d),
        .busy_out(busy_d), .frame_done_out(done_d)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ray for pixel (i,j) = forward + rstep*(i - H/2) + ustep*(V/2 - j), rstep/ustep from Q16.16 scaling.
    function automatic logic [31:0] mdl(input int fc, input int rc, input int uc,
                                        input int i, input int j, input int h, input int v,
                                        input int step);
        longint rs, us, val;
        rs  = (longint'(rc) * longint'(step)) >>> 16;
        us  = (longint'(uc) * longint'(step)) >>> 16;
        rs  = longint'(int'(rs));
        us  = longint'(int'(us));
        val = longint'(fc) + rs * longint'(i - h / 2) + us * longint'(v / 2 - j);
        return val[31:0];
    endfunction

    task automatic set_basis();
        xf = F[0]; yf = F[1]; zf = F[2];
        xr = R[0]; yr = R[1]; zr = R[2];
        xu = U[0]; yu = U[1]; zu = U[2];
    endtask

    task automatic small_frame(input bit rand_ready, input bit perturb, input bit abort);
        int cyc, k, first_v, done_cyc;
        bit prev_stall, fin;
        logic [127:0] snap;
        cyc = 0; k = 0; first_v = -1; done_cyc = -1; prev_stall = 0; fin = 0; snap = '0;
        set_basis();
        fs_s = 1'b1;
        rdy_s = 1'b1;
        while (!fin && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                fs_s = 1'b0;
                check("busy_after_start", busy_s, 1);
                if (perturb) begin xr = 0; yr = 65536; end
            end
            if (perturb && cyc == 5) fs_s = 1'b1;
            if (perturb && cyc == 6) fs_s = 1'b0;
            if (prev_stall) check("stall_hold", {v_s, rx_s, ry_s, rz_s, px_s, py_s}, snap);
            prev_stall = 0;
            if (abort && v_s && k == 2) begin
                #2 rst = 1'b1;
                #1;
                check("abort_outputs_zero",
                      {v_s, busy_s, done_s, rx_s, ry_s, rz_s, px_s, py_s}, '0);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("abort_no_done", done_s, 0);
                end
                rst = 1'b0;
                fin = 1;
            end else if (done_s) begin
                done_cyc = cyc;
                check("done_valid_low", v_s, 0);
                check("done_busy_low", busy_s, 0);
                @(posedge clk); #1;
                check("done_single_pulse", {done_s, busy_s}, 0);
                fin = 1;
            end else if (v_s) begin
                if (first_v < 0) first_v = cyc;
                rdy_s = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rdy_s) begin
                    check("ray_pixel", {px_s, py_s}, {2'(k % 4), 1'(k / 4)});
                    check("ray_vec", {rx_s, ry_s, rz_s},
                          {mdl(F[0], R[0], U[0], k % 4, k / 4, 4, 2, 16384),
                           mdl(F[1], R[1], U[1], k % 4, k / 4, 4, 2, 16384),
                           mdl(F[2], R[2], U[2], k % 4, k / 4, 4, 2, 16384)});
                    $display("ray k=%0d px=%0d py=%0d x=%0d y=%0d z=%0d cyc=%0d",
                             k, px_s, py_s, $signed(rx_s), $signed(ry_s), $signed(rz_s), cyc);
                    k++;
                end else begin
                    prev_stall = 1;
                    snap = {v_s, rx_s, ry_s, rz_s, px_s, py_s};
                end
            end
        end
        rdy_s = 1'b1;
        fs_s  = 1'b0;
        check("frame_finished", fin, 1);
        check("first_valid_cycle", first_v, 3);
        if (abort) begin
            check("abort_handshakes", k, 2);
        end else begin
            check("handshakes", k, 8);
            if (!rand_ready) check("done_cycle", done_cyc, 11);
        end
    endtask

    task automatic default_frame();
        int cyc, k, errs;
        bit seen_done;
        logic [31:0] e;
        cyc = 0; k = 0; errs = 0; seen_done = 0;
        set_basis();
        fs_d = 1'b1;
        rdy_d = 1'b1;
        while (!seen_done && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) fs_d = 1'b0;
            if (done_d) begin
                seen_done = 1;
            end else if (v_d) begin
                if (k == 0) begin
                    e = -65600; check("dflt_first_x", rx_d, e);
                    e = 36900;  check("dflt_first_y", ry_d, e);
                    e = 65536;  check("dflt_first_z", rz_d, e);
                end
                if (px_d == 9'd160 && py_d == 8'd90) begin
                    check("dflt_center_index", k, 90 * 320 + 160);
                    check("dflt_center_vec", {rx_d, ry_d, rz_d}, {32'd0, 32'd0, 32'd65536});
                end
                if ({px_d, py_d} !== {9'(k % 320), 8'(k / 320)} ||
                    rx_d !== mdl(F[0], R[0], U[0], k % 320, k / 320, 320, 180, 410) ||
                    ry_d !== mdl(F[1], R[1], U[1], k % 320, k / 320, 320, 180, 410) ||
                    rz_d !== mdl(F[2], R[2], U[2], k % 320, k / 320, 320, 180, 410))
                    errs++;
                k++;
            end
        end
        $display("default frame: handshakes=%0d model_mismatches=%0d cycles=%0d", k, errs, cyc);
        check("dflt_done_seen", seen_done, 1);
        check("dflt_handshakes", k, 57600);
        check("dflt_all_rays", errs, 0);
    endtask

    initial begin
        rst = 1'b1;
        fs_s = 1'b0; rdy_s = 1'b1; fs_d = 1'b0; rdy_d = 1'b1;
        xf = 32'd7; yf = 32'd7; zf = 32'd7; xu = 32'd7; yu = 32'd7; zu = 32'd7;
        xr = 32'd7; yr = 32'd7; zr = 32'd7;
        #12;
        check("reset_outputs_s", {v_s, busy_s, done_s, rx_s, ry_s, rz_s, px_s, py_s}, '0);
        check("reset_outputs_d", {v_d, busy_d, done_d, rx_d, ry_d, rz_d, px_d, py_d}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        small_frame(1'b0, 1'b0, 1'b0);
        small_frame(1'b1, 1'b0, 1'b0);
        small_frame(1'b0, 1'b1, 1'b0);
        small_frame(1'b0, 1'b0, 1'b1);
        small_frame(1'b0, 1'b0, 1'b0);
        default_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
